// File: rtl/hazard_pkg.sv
// Shared definitions for the S3 hazard controller: instruction flag bit map,
// controller state encoding and the default MUL/DIV occupancy.
package hazard_pkg;

    localparam int FLAG_LOAD      = 0;
    localparam int FLAG_STORE     = 1;
    localparam int FLAG_BRANCH    = 2;
    localparam int FLAG_JUMP      = 3;
    localparam int FLAG_MULDIV    = 4;
    localparam int FLAG_WRITES_RD = 5;
    localparam int FLAG_USES_IMM  = 6;

    localparam int MULDIV_LAT_DEF = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl_s3.sv
// Hazard controller for the PC, IF/ID and ID/S3 latches: redirect flushes,
// MUL/DIV holds and load-use bubbles, plus stall/flush performance counters.
module hazard_ctrl_s3
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             s3_valid,
    input  logic [4:0]       s3_rd,
    input  logic [6:0]       s3_flags,
    input  logic             s3_redirect,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_s3_enable,
    output logic             id_s3_flush,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam bit         MC_HOLD   = (MULDIV_LAT > 1);
    localparam logic [7:0] CNT_START = 8'(MC_HOLD ? MULDIV_LAT - 2 : 0);

    hz_state_t  state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       load_use, redirect_evt;

    // x0 is hardwired zero, so a load targeting it can never be a dependency.
    assign load_use = s3_valid && s3_flags[FLAG_LOAD] && s3_flags[FLAG_WRITES_RD]
                   && (s3_rd != 5'd0) && id_valid
                   && ((id_uses_rs1 && (id_rs1 == s3_rd)) ||
                       (id_uses_rs2 && (id_rs2 == s3_rd)));

    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        id_s3_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_s3_flush  = 1'b0;
        redirect_evt = 1'b0;
        state_nx     = state;
        cnt_nx       = cnt;
        if (rst) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_s3_enable = 1'b0;
            if_id_flush  = 1'b1;
            id_s3_flush  = 1'b1;
            state_nx     = RUN;
            cnt_nx       = '0;
        end else if (state == RUN) begin
            if (s3_valid && s3_redirect) begin
                if_id_flush  = 1'b1;
                id_s3_flush  = 1'b1;
                redirect_evt = 1'b1;
            end else if (MC_HOLD && s3_valid && s3_flags[FLAG_MULDIV]) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_s3_enable = 1'b0;
                state_nx     = MC_BUSY;
                cnt_nx       = CNT_START;
            end else if (load_use) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_s3_flush  = 1'b1;
            end
        end else if (cnt != '0) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_s3_enable = 1'b0;
            cnt_nx       = cnt - 1'b1;
        end else begin
            // Release cycle: the MUL/DIV result may still feed a dependent in ID.
            state_nx = RUN;
            if (load_use) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_s3_flush  = 1'b1;
            end
        end
    end

    assign mc_busy = !rst && (state == MC_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_enable),
        .count (stall_cycles)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_evt),
        .count (flush_events)
    );

    redirect_in_hold: assert property (@(posedge clk) disable iff (rst)
        (state == MC_BUSY) |-> !(s3_valid && s3_redirect));

endmodule

// File: tb/tb_hazard_ctrl_s3.sv
// Directed-vector bench for hazard_ctrl_s3; a second CNT_W=4 instance shares
// the stimulus to exercise counter saturation.
module tb_hazard_ctrl_s3;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, s3_valid, s3_redirect;
    logic [4:0] id_rs1, id_rs2, s3_rd;
    logic [6:0] s3_flags;

    logic        pc_en, ifid_en, ifid_fl, ids3_en, ids3_fl, busy;
    logic [31:0] stall_cycles, flush_events;
    logic        pc_en4, ifid_en4, ifid_fl4, ids3_en4, ids3_fl4, busy4;
    logic [3:0]  stall4, flush4;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    localparam logic [6:0] F_LD  = 7'b0100001;  // LOAD | WRITES_RD
    localparam logic [6:0] F_MD  = 7'b0110000;  // MULDIV | WRITES_RD
    localparam logic [6:0] F_ST  = 7'b0000010;  // STORE only
    // control vector {pc_en, ifid_en, ifid_fl, ids3_en, ids3_fl, busy}
    localparam logic [5:0] C_RST = 6'b001010;
    localparam logic [5:0] C_DEF = 6'b110100;
    localparam logic [5:0] C_LU  = 6'b000110;
    localparam logic [5:0] C_HLD = 6'b000000;
    localparam logic [5:0] C_BSY = 6'b000001;
    localparam logic [5:0] C_REL = 6'b110101;
    localparam logic [5:0] C_RDR = 6'b111110;

    always #5 clk = ~clk;

    hazard_ctrl_s3 #(.MULDIV_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .s3_valid(s3_valid),
        .s3_rd(s3_rd), .s3_flags(s3_flags), .s3_redirect(s3_redirect),
        .pc_enable(pc_en), .if_id_enable(ifid_en), .if_id_flush(ifid_fl),
        .id_s3_enable(ids3_en), .id_s3_flush(ids3_fl), .mc_busy(busy),
        .stall_cycles(stall_cycles), .flush_events(flush_events));

    hazard_ctrl_s3 #(.MULDIV_LAT(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .s3_valid(s3_valid),
        .s3_rd(s3_rd), .s3_flags(s3_flags), .s3_redirect(s3_redirect),
        .pc_enable(pc_en4), .if_id_enable(ifid_en4), .if_id_flush(ifid_fl4),
        .id_s3_enable(ids3_en4), .id_s3_flush(ids3_fl4), .mc_busy(busy4),
        .stall_cycles(stall4), .flush_events(flush4));

    wire [5:0] ctl = {pc_en, ifid_en, ifid_fl, ids3_en, ids3_fl, busy};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs are driven from here
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_s3(input logic v, input logic [4:0] rd, input logic [6:0] fl,
                          input logic rdr);
        s3_valid = v; s3_rd = rd; s3_flags = fl; s3_redirect = rdr;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
        id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    endtask

    initial begin
        rst = 1'b1;
        set_s3(0, 0, 0, 0);
        set_id(0, 0, 0, 0, 0);
        cyc(); cyc();
        #1;
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_stall", stall_cycles, 0);
        chk("rst_flush", flush_events, 0);
        rst = 1'b0;
        #1 chk("idle_ctl", 32'(ctl), 32'(C_DEF));

        // load-use on rs1
        cyc();
        set_s3(1, 5'd5, F_LD, 0); set_id(1, 5'd5, 1, 5'd0, 0);
        #1 chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
        exp_stall++;
        cyc();
        set_s3(0, 0, 0, 0);
        #1 chk("lu_after_ctl", 32'(ctl), 32'(C_DEF));
        chk("lu_stall", stall_cycles, 32'(exp_stall));

        // x0 destination, unused rs2, store without rd: no bubble
        set_s3(1, 5'd0, F_LD, 0); set_id(1, 5'd0, 1, 5'd0, 1);
        #1 chk("x0_ctl", 32'(ctl), 32'(C_DEF));
        set_s3(1, 5'd5, F_LD, 0); set_id(1, 5'd3, 1, 5'd5, 0);
        #1 chk("unused_rs2_ctl", 32'(ctl), 32'(C_DEF));
        set_s3(1, 5'd5, F_ST, 0); set_id(1, 5'd5, 1, 5'd5, 1);
        #1 chk("store_ctl", 32'(ctl), 32'(C_DEF));
        set_s3(1, 5'd5, F_LD, 0); set_id(0, 5'd5, 1, 5'd5, 1);
        #1 chk("id_invalid_ctl", 32'(ctl), 32'(C_DEF));
        // used rs2 does match
        set_s3(1, 5'd5, F_LD, 0); set_id(1, 5'd3, 1, 5'd5, 1);
        #1 chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
        exp_stall++;
        cyc();
        set_s3(0, 0, 0, 0); set_id(0, 0, 0, 0, 0);
        #1 chk("lu_rs2_stall", stall_cycles, 32'(exp_stall));

        // MUL/DIV hold, LAT=4
        set_s3(1, 5'd7, F_MD, 0);
        #1 chk("md_c1_ctl", 32'(ctl), 32'(C_HLD));
        cyc(); #1 chk("md_c2_ctl", 32'(ctl), 32'(C_BSY));
        cyc(); #1 chk("md_c3_ctl", 32'(ctl), 32'(C_BSY));
        cyc(); #1 chk("md_c4_ctl", 32'(ctl), 32'(C_REL));
        exp_stall += 3;
        chk("md_stall", stall_cycles, 32'(exp_stall));
        // back-to-back: new MUL/DIV retriggers straight from RUN
        cyc(); #1 chk("md_b2b_ctl", 32'(ctl), 32'(C_HLD));
        cyc(); #1 chk("md_b2b_c2_ctl", 32'(ctl), 32'(C_BSY));
        cyc(); // cnt == 1 here
        rst = 1'b1;
        #1 chk("rst_mid_ctl", 32'(ctl), 32'(C_RST));
        cyc();
        set_s3(0, 0, 0, 0);
        rst = 1'b0;
        #1 chk("post_rst_ctl", 32'(ctl), 32'(C_DEF));
        chk("post_rst_stall", stall_cycles, 0);
        chk("post_rst_flush", flush_events, 0);
        exp_stall = 0;

        // redirect beats a simultaneous load-use
        set_s3(1, 5'd5, F_LD, 1); set_id(1, 5'd5, 1, 5'd0, 0);
        #1 chk("rdr_ctl", 32'(ctl), 32'(C_RDR));
        cyc();
        set_s3(0, 5'd5, F_LD, 1);
        #1 chk("rdr_invalid_ctl", 32'(ctl), 32'(C_DEF));
        chk("rdr_flush", flush_events, 1);
        chk("rdr_stall", stall_cycles, 32'(exp_stall));

        // saturation: 20 stall cycles
        set_s3(1, 5'd9, F_LD, 0); set_id(1, 5'd9, 1, 5'd0, 0);
        repeat (20) cyc();
        set_s3(0, 0, 0, 0);
        #1;
        chk("sat_stall32", stall_cycles, 20);
        chk("sat_stall4", 32'(stall4), 15);
        chk("sat_flush4", 32'(flush4), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_s3.md
Name: hazard_ctrl_s3

Overview:
Pipeline hazard controller that drives the enable/flush controls of the PC register, the IF/ID latch and the ID/S3 latch.
- Inputs: ID-stage source registers and the ID/S3 latch outputs (rd, instr_flags, valid), plus the S3 branch/jump resolution.
- Handles three hazards: load-use bubbles, multi-cycle MUL/DIV holds and taken-branch/jump flushes.
- Keeps saturating stall and flush performance counters.

Parameters:
MULDIV_LAT, 4, total cycles a MUL/DIV instruction occupies S3 (legal range 1..255; 1 = no hold)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  IF/ID latch holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
s3_valid  in  1  ID/S3 latch holds a real instruction
s3_rd  in  5  rd_out of the ID/S3 latch
s3_flags  in  7  instr_flags_out of the ID/S3 latch
s3_redirect  in  1  S3 resolved a taken branch or a jump this cycle
pc_enable  out  1  PC register may update
if_id_enable  out  1  IF/ID latch enable
if_id_flush  out  1  IF/ID latch flush
id_s3_enable  out  1  ID/S3 latch enable
id_s3_flush  out  1  ID/S3 latch flush (latch gives flush priority over enable)
mc_busy  out  1  MUL/DIV hold in progress
stall_cycles  out  CNT_W  saturating count of cycles with pc_enable=0
flush_events  out  CNT_W  saturating count of redirect flushes

Behaviour:
- s3_flags bit map: [0] LOAD, [1] STORE, [2] BRANCH, [3] JUMP, [4] MULDIV, [5] WRITES_RD, [6] USES_IMM.
- Control outputs are combinational from state, cnt and inputs, so they act in the same cycle. Counters, state and cnt are registered.
- While rst=1:
  - pc_enable=0, if_id_enable=0, id_s3_enable=0.
  - if_id_flush=1, id_s3_flush=1.
  - mc_busy=0, state=RUN, cnt=0, both counters=0.
  - Reset mid-hold abandons the hold.
- Default in RUN, no hazard: all enables=1, all flushes=0.
- Priority in RUN (highest first): redirect > MUL/DIV start > load-use.
- Redirect, when s3_valid & s3_redirect:
  - pc_enable=1, if_id_flush=1, id_s3_flush=1.
  - flush_events increments.
- MUL/DIV start, when s3_valid & s3_flags[4] & MULDIV_LAT>1:
  - all enables=0, flushes=0.
  - next state MC_BUSY, cnt <= MULDIV_LAT-2.
- Load-use, when s3_valid & s3_flags[0] & s3_flags[5] & s3_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==s3_rd) | (id_uses_rs2 & id_rs2==s3_rd)):
  - pc_enable=0, if_id_enable=0, id_s3_flush=1 (inserts exactly one bubble).
  - Register x0 never creates a hazard.
- MC_BUSY:
  - mc_busy=1.
  - cnt!=0: hold everything (all enables=0, flushes=0), cnt decrements.
  - cnt==0: release (default enables), go to RUN. Load-use is evaluated in this cycle too, against the MUL/DIV rd, and applied if it matches.
  - Total S3 occupancy of the MUL/DIV = MULDIV_LAT cycles.
  - s3_redirect in MC_BUSY is illegal: ignored, flagged by an assertion.
- Back-to-back MUL/DIV: the next one enters S3 on the release edge and retriggers from RUN with no gap.
- stall_cycles increments every cycle with pc_enable=0 while rst=0. Both counters saturate at all-ones.

Decomposition:
- hazard_pkg holds:
  - flag bit indices FLAG_LOAD..FLAG_USES_IMM
  - state enum {RUN, MC_BUSY}
  - default MULDIV_LAT
- One natural sub-module: hazard_perf_cnt, a saturating counter with inc and async active-high rst, instantiated twice.

Test Plan:
- Load-use: s3 LOAD rd=5 valid; ID rs1=5 uses_rs1 -> one cycle of pc_enable=0, if_id_enable=0, id_s3_flush=1; next cycle all defaults; stall_cycles=1.
- x0 and unused-operand cases: same as above with rd=0, or rs2=5 and uses_rs2=0 -> no stall, all enables 1.
- MUL/DIV with MULDIV_LAT=4: MULDIV enters S3 -> enables 0 for 3 cycles, mc_busy=1 for cycles 2-4, release on cycle 4; stall_cycles=3.
- Redirect while a load-use condition is also true -> pc_enable=1, both flushes=1, no bubble; flush_events=1.
- Reset mid-MC_BUSY: assert rst at cnt=1 -> outputs immediately take reset values; after deassert, state is RUN and counters are 0.
- Saturation with CNT_W=4: hold stall for 20 cycles -> stall_cycles stops at 15.
